// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for ram_arbiter: two request ports (A, B) and the busy flag.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ack;
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ack;
    logic              busy;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_rdata, a_ack, b_rdata, b_ack, busy
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_rdata, a_ack, b_rdata, b_ack, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port RAM with a shared bidirectional data bus.
// Read: IDLE-SETUP-CAPTURE-DONE; write: IDLE-SETUP-STROBE-RELEASE-DONE.
module ram_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] ram_addr,
    inout  logic [DATA_W-1:0] ram_data,
    output logic              ram_wre
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        CAPTURE,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt_b_q, gnt_b_d;
    logic              last_b_q, last_b_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              pick_b;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_b_d   = gnt_b_q;
        last_b_d  = last_b_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        pick_b    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // B wins only when alone, or on a round-robin tie after A was served last
                    pick_b   = bus.b_req && (!bus.a_req || (!FIXED_PRIO && !last_b_q));
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = pick_b ? bus.b_we    : bus.a_we;
                    addr_d   = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d  = pick_b ? bus.b_wdata : bus.a_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP:   state_d = we_q ? STROBE : CAPTURE;
            STROBE:  state_d = RELEASE;
            RELEASE: state_d = DONE;
            CAPTURE: begin
                if (gnt_b_q) begin
                    b_rdata_d = ram_data;
                end else begin
                    a_rdata_d = ram_data;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_b_q   <= gnt_b_d;
            last_b_q  <= last_b_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobe decoded straight from the state flop so an async reset drops it at once
    assign ram_wre     = (state_q == STROBE);
    assign ram_data    = ram_wre ? wdata_q : 'z;
    assign ram_addr    = addr_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.a_ack   = (state_q == DONE) && !gnt_b_q;
    assign bus.b_ack   = (state_q == DONE) && gnt_b_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: round-robin instance dut0 and fixed-priority instance dut1,
// each in front of a behavioural single-port RAM that commits writes on a clock edge with ram_wre high.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic ram_init;
    int   tests = 0;
    int   fails = 0;
    int   mon_err = 0;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
    ram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

    logic [7:0]  ram_addr0, ram_addr1;
    logic        ram_wre0, ram_wre1;
    wire  [31:0] ram_data0, ram_data1;
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] model [256];
    logic [31:0] exp_a, exp_b;

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int unsigned i);
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    ram_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_wre(ram_wre0));

    ram_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_wre(ram_wre1));

    // RAM drives the bus whenever it is not being written
    assign ram_data0 = ram_wre0 ? 'z : mem0[ram_addr0];
    assign ram_data1 = ram_wre1 ? 'z : mem1[ram_addr1];

    always @(posedge clk or posedge ram_init) begin
        if (ram_init) begin
            for (int unsigned i = 0; i < 256; i++) begin
                mem0[i] <= pat(i);
                mem1[i] <= pat(i);
            end
        end else begin
            if (ram_wre0) mem0[ram_addr0] <= ram_data0;
            if (ram_wre1) mem1[ram_addr1] <= ram_data1;
        end
    end

    // Bus watch: no X, no contention while the RAM drives, never two acks at once
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ($isunknown(ram_data0) || $isunknown(ram_data1)) mon_err++;
            if (!ram_wre0 && ram_data0 !== mem0[ram_addr0]) mon_err++;
            if (!ram_wre1 && ram_data1 !== mem1[ram_addr1]) mon_err++;
            if (bus0.a_ack && bus0.b_ack) mon_err++;
            if (bus1.a_ack && bus1.b_ack) mon_err++;
        end
    end

    task automatic drive0(input bit pb, input bit we, input logic [7:0] addr, input logic [31:0] wd);
        if (pb) begin
            bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wd; bus0.b_req = 1'b1;
        end else begin
            bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wd; bus0.a_req = 1'b1;
        end
    endtask

    // Single access on dut0; lat counts negedges from the grant (IDLE) cycle, -1 on timeout
    task automatic access0(input bit pb, input bit we, input logic [7:0] addr, input logic [31:0] wd,
                           output int lat, output int wre_cnt, output bit stray);
        bit done = 1'b0;
        lat = -1; wre_cnt = 0; stray = 1'b0;
        drive0(pb, we, addr, wd);
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (ram_wre0) wre_cnt++;
            if (pb ? bus0.a_ack : bus0.b_ack) stray = 1'b1;
            if (pb ? bus0.b_ack : bus0.a_ack) begin lat = n; done = 1'b1; end
        end
        if (pb) bus0.b_req = 1'b0; else bus0.a_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bit found = 1'b0;
        int acks = 0, lat, wc;
        bit stray;
        rst_n = 1'b0; #2;
        tests++; if (bus0.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        tests++; if ({bus0.a_ack, bus0.b_ack} !== 2'b00) begin fails++; $display("FAIL reset_ack: got %b expected 00", {bus0.a_ack, bus0.b_ack}); end
        tests++; if (bus0.a_rdata !== 32'h0) begin fails++; $display("FAIL reset_a_rdata: got %h expected 0", bus0.a_rdata); end
        tests++; if (bus0.b_rdata !== 32'h0) begin fails++; $display("FAIL reset_b_rdata: got %h expected 0", bus0.b_rdata); end
        tests++; if (ram_wre0 !== 1'b0) begin fails++; $display("FAIL reset_wre: got %b expected 0", ram_wre0); end
        tests++; if (ram_addr0 !== 8'h00) begin fails++; $display("FAIL reset_addr: got %h expected 00", ram_addr0); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // Abort a write to 0x10 in the middle of its strobe cycle
        drive0(1'b0, 1'b1, 8'h10, 32'h1234_5678);
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (ram_wre0) found = 1'b1;
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL abort_strobe_seen: got %b expected 1", found); end
        rst_n = 1'b0; #1;
        tests++; if (ram_wre0 !== 1'b0) begin fails++; $display("FAIL abort_wre: got %b expected 0", ram_wre0); end
        tests++; if (bus0.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", bus0.busy); end
        tests++; if (ram_data0 !== model[0]) begin fails++; $display("FAIL abort_bus_released: got %h expected %h", ram_data0, model[0]); end
        bus0.a_req = 1'b0;
        repeat (3) begin @(negedge clk); if (bus0.a_ack) acks++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (bus0.a_ack) acks++; end
        tests++; if (acks !== 0) begin fails++; $display("FAIL abort_no_ack: got %0d expected 0", acks); end
        @(posedge clk); #1;
        access0(1'b0, 1'b0, 8'h10, 32'h0, lat, wc, stray);
        tests++; if (lat !== 3) begin fails++; $display("FAIL abort_read_lat: got %0d expected 3", lat); end
        tests++; if (bus0.a_rdata !== model[8'h10]) begin fails++; $display("FAIL abort_read_data: got %h expected %h", bus0.a_rdata, model[8'h10]); end
    endtask

    task automatic test_write_read();
        int lat, wc;
        bit stray;
        access0(1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF, lat, wc, stray);
        model[8'h05] = 32'hDEAD_BEEF;
        tests++; if (lat !== 4) begin fails++; $display("FAIL wr_lat: got %0d expected 4", lat); end
        tests++; if (wc !== 1) begin fails++; $display("FAIL wr_strobe_cycles: got %0d expected 1", wc); end
        tests++; if (stray !== 1'b0) begin fails++; $display("FAIL wr_stray_ack: got %b expected 0", stray); end
        access0(1'b0, 1'b0, 8'h05, 32'h0, lat, wc, stray);
        tests++; if (lat !== 3) begin fails++; $display("FAIL rd_lat: got %0d expected 3", lat); end
        tests++; if (wc !== 0) begin fails++; $display("FAIL rd_strobe_cycles: got %0d expected 0", wc); end
        tests++; if (bus0.a_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", bus0.a_rdata); end
    endtask

    task automatic test_round_robin();
        int lat, wc, a_n = -1, b_n = -1, k = 0, extra = 0;
        bit stray;
        int ack_n [4];
        bit ack_b [4];
        logic [31:0] rd [4];
        // Make B the last served so A wins the first tie
        access0(1'b1, 1'b0, 8'h30, 32'h0, lat, wc, stray);
        tests++; if (bus0.b_rdata !== model[8'h30]) begin fails++; $display("FAIL rr_pre_b: got %h expected %h", bus0.b_rdata, model[8'h30]); end
        drive0(1'b0, 1'b0, 8'h01, 32'h0);
        drive0(1'b1, 1'b1, 8'h02, 32'hCAFE_F00D);
        for (int n = 0; n < 30 && (a_n < 0 || b_n < 0); n++) begin
            @(negedge clk);
            if (bus0.a_ack) begin a_n = n; bus0.a_req = 1'b0; exp_a = bus0.a_rdata; end
            if (bus0.b_ack) begin b_n = n; bus0.b_req = 1'b0; end
        end
        @(posedge clk); #1;
        model[8'h02] = 32'hCAFE_F00D;
        tests++; if (a_n !== 3) begin fails++; $display("FAIL rr1_a_cycle: got %0d expected 3", a_n); end
        tests++; if (b_n !== 8) begin fails++; $display("FAIL rr1_b_cycle: got %0d expected 8", b_n); end
        tests++; if (exp_a !== model[8'h01]) begin fails++; $display("FAIL rr1_a_data: got %h expected %h", exp_a, model[8'h01]); end
        // A alone: read-after-write ordering, and A becomes last served
        access0(1'b0, 1'b0, 8'h02, 32'h0, lat, wc, stray);
        tests++; if (bus0.a_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL rr_raw: got %h expected cafef00d", bus0.a_rdata); end
        drive0(1'b0, 1'b0, 8'h02, 32'h0);
        drive0(1'b1, 1'b0, 8'h01, 32'h0);
        for (int n = 0; n < 40 && k < 4; n++) begin
            @(negedge clk);
            if (bus0.a_ack || bus0.b_ack) begin
                ack_n[k] = n;
                ack_b[k] = bus0.b_ack;
                rd[k] = bus0.b_ack ? bus0.b_rdata : bus0.a_rdata;
                k++;
                if (k == 4) begin bus0.a_req = 1'b0; bus0.b_req = 1'b0; end
            end
        end
        repeat (8) begin @(negedge clk); if (bus0.a_ack || bus0.b_ack) extra++; end
        @(posedge clk); #1;
        tests++; if (k !== 4) begin fails++; $display("FAIL rr2_ack_count: got %0d expected 4", k); end
        for (int j = 0; j < k; j++) begin
            tests++; if (ack_b[j] !== ((j & 1) == 0)) begin fails++; $display("FAIL rr2_order[%0d]: got b=%b expected b=%b", j, ack_b[j], ((j & 1) == 0)); end
            tests++; if (ack_n[j] !== 3 + 4 * j) begin fails++; $display("FAIL rr2_cycle[%0d]: got %0d expected %0d", j, ack_n[j], 3 + 4 * j); end
            tests++; if (rd[j] !== (ack_b[j] ? model[8'h01] : model[8'h02])) begin fails++; $display("FAIL rr2_data[%0d]: got %h expected %h", j, rd[j], ack_b[j] ? model[8'h01] : model[8'h02]); end
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL rr2_extra_ack: got %0d expected 0", extra); end
        exp_a = model[8'h02];
        exp_b = model[8'h01];
    endtask

    task automatic test_fixed_prio();
        int na = 0, nb = 0;
        bus1.a_we = 1'b0; bus1.a_addr = 8'h03; bus1.a_wdata = '0;
        bus1.b_we = 1'b0; bus1.b_addr = 8'h04; bus1.b_wdata = '0;
        bus1.a_req = 1'b1; bus1.b_req = 1'b1;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (bus1.a_ack) na++;
            if (bus1.b_ack) nb++;
        end
        bus1.a_req = 1'b0; bus1.b_req = 1'b0;
        @(posedge clk); #1;
        tests++; if (na !== 8) begin fails++; $display("FAIL fp_a_acks: got %0d expected 8", na); end
        tests++; if (nb !== 0) begin fails++; $display("FAIL fp_b_acks: got %0d expected 0", nb); end
        tests++; if (bus1.a_rdata !== pat(3)) begin fails++; $display("FAIL fp_a_data: got %h expected %h", bus1.a_rdata, pat(3)); end
        tests++; if (bus1.b_rdata !== 32'h0) begin fails++; $display("FAIL fp_b_data: got %h expected 0", bus1.b_rdata); end
    endtask

    task automatic test_random();
        int ops = 0, it = 0;
        bit last_b = 1'b0;
        while (ops < 200) begin
            bit ra, rb, awe, bwe, first_b, a_got, b_got;
            int stray = 0;
            logic [7:0] aa, ba;
            logic [31:0] awd, bwd;
            ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            awe = 1'($urandom_range(0, 1)); bwe = 1'($urandom_range(0, 1));
            aa = 8'h40 + 8'($urandom_range(0, 7)); ba = 8'h40 + 8'($urandom_range(0, 7));
            awd = $urandom; bwd = $urandom;
            first_b = rb && (!ra || !last_b);
            for (int s = 0; s < 2; s++) begin
                bit sb = (s == 0) ? first_b : !first_b;
                if (sb && rb) begin
                    if (bwe) model[ba] = bwd; else exp_b = model[ba];
                end else if (!sb && ra) begin
                    if (awe) model[aa] = awd; else exp_a = model[aa];
                end
            end
            last_b = (ra && rb) ? !first_b : rb;
            if (ra) drive0(1'b0, awe, aa, awd);
            if (rb) drive0(1'b1, bwe, ba, bwd);
            a_got = 1'b0; b_got = 1'b0;
            for (int n = 0; n < 40 && (a_got != ra || b_got != rb); n++) begin
                @(negedge clk);
                if (bus0.a_ack) begin if (!ra || a_got) stray++; a_got = 1'b1; bus0.a_req = 1'b0; end
                if (bus0.b_ack) begin if (!rb || b_got) stray++; b_got = 1'b1; bus0.b_req = 1'b0; end
            end
            @(posedge clk); #1;
            tests++; if ({a_got, b_got} !== {ra, rb}) begin fails++; $display("FAIL rnd_acks[%0d]: got %b expected %b", it, {a_got, b_got}, {ra, rb}); end
            tests++; if (stray !== 0) begin fails++; $display("FAIL rnd_stray[%0d]: got %0d expected 0", it, stray); end
            tests++; if (bus0.a_rdata !== exp_a) begin fails++; $display("FAIL rnd_a_rdata[%0d]: got %h expected %h", it, bus0.a_rdata, exp_a); end
            tests++; if (bus0.b_rdata !== exp_b) begin fails++; $display("FAIL rnd_b_rdata[%0d]: got %h expected %h", it, bus0.b_rdata, exp_b); end
            ops += int'(ra) + int'(rb);
            it++;
        end
    endtask

    task automatic test_drop_after_grant();
        int pulses = 0, first = -1;
        drive0(1'b0, 1'b0, 8'h7F, 32'h0);
        @(posedge clk); #1;
        bus0.a_req = 1'b0;
        bus0.a_addr = 8'h00;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus0.a_ack) begin pulses++; if (first < 0) first = n; end
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL drop_pulses: got %0d expected 1", pulses); end
        tests++; if (first !== 2) begin fails++; $display("FAIL drop_ack_cycle: got %0d expected 2", first); end
        tests++; if (bus0.a_rdata !== model[8'h7F]) begin fails++; $display("FAIL drop_data: got %h expected %h", bus0.a_rdata, model[8'h7F]); end
        tests++; if (bus0.busy !== 1'b0) begin fails++; $display("FAIL drop_idle: got %b expected 0", bus0.busy); end
    endtask

    task automatic test_bus_monitor();
        tests++; if (mon_err !== 0) begin fails++; $display("FAIL bus_monitor: got %0d events expected 0", mon_err); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        ram_init = 1'b0;
        {bus0.a_req, bus0.a_we, bus0.a_addr, bus0.a_wdata} = '0;
        {bus0.b_req, bus0.b_we, bus0.b_addr, bus0.b_wdata} = '0;
        {bus1.a_req, bus1.a_we, bus1.a_addr, bus1.a_wdata} = '0;
        {bus1.b_req, bus1.b_we, bus1.b_addr, bus1.b_wdata} = '0;
        for (int unsigned i = 0; i < 256; i++) model[i] = pat(i);
        exp_a = '0;
        exp_b = '0;
        #1 ram_init = 1'b1;
        #1 ram_init = 1'b0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_prio();
        test_random();
        test_drop_after_grant();
        test_bus_monitor();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
